// File: rtl/matrix_operand_streamer.sv
// Streams A/B operand pairs from a single-port memory as packed 4-element beats.
// Six cycles per beat: four memory reads, one final capture, one send/stall state.
module matrix_operand_streamer #(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned NUM_ELEMENTS = 4,
  parameter int unsigned MATRIX_WIDTH = 4,
  parameter int unsigned ADDR_W       = 8,
  parameter int unsigned A_BASE       = 0,
  parameter int unsigned B_BASE       = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  output logic                          busy,
  output logic                          done,
  output logic                          mem_rd,
  output logic [ADDR_W-1:0]             mem_addr,
  input  logic [WIDTH-1:0]              mem_rdata,
  input  logic                          out_ready,
  output logic [NUM_ELEMENTS*WIDTH-1:0] rdata,
  output logic                          read_en,
  output logic                          out_last
);

  localparam int unsigned CW = $clog2(MATRIX_WIDTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LAST,
    S_SEND,
    S_DONE
  } state_t;

  state_t                          state_q, state_d;
  logic [1:0]                      k_q, k_d;
  logic [CW-1:0]                   r_q, r_d;
  logic [CW-1:0]                   c_q, c_d;
  logic [WIDTH-1:0]                slot_q [3];
  logic [WIDTH-1:0]                slot_d [3];
  logic [NUM_ELEMENTS*WIDTH-1:0]   rdata_q, rdata_d;
  logic [ADDR_W-1:0]               addr_row;
  logic                            final_beat;

  assign final_beat = (r_q == CW'(MATRIX_WIDTH - 2)) && (c_q == CW'(MATRIX_WIDTH - 1));
  // k[0] selects row r/r+1, k[1] selects matrix A/B.
  assign addr_row   = ADDR_W'(r_q) + ADDR_W'(k_q[0]);
  assign rdata      = rdata_q;

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    r_d      = r_q;
    c_d      = c_q;
    slot_d   = slot_q;
    rdata_d  = rdata_q;
    busy     = (state_q != S_IDLE);
    done     = (state_q == S_DONE);
    mem_rd   = 1'b0;
    mem_addr = '0;
    read_en  = 1'b0;
    out_last = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FETCH;
          k_d     = 2'd0;
          r_d     = '0;
          c_d     = '0;
        end
      end
      S_FETCH: begin
        mem_rd   = 1'b1;
        mem_addr = (k_q[1] ? ADDR_W'(B_BASE) : ADDR_W'(A_BASE))
                 + addr_row * ADDR_W'(MATRIX_WIDTH) + ADDR_W'(c_q);
        if (k_q != 2'd0) begin
          slot_d[k_q - 2'd1] = mem_rdata;
        end
        k_d = k_q + 2'd1;
        if (k_q == 2'd3) begin
          state_d = S_LAST;
        end
      end
      S_LAST: begin
        // Output register only updates here, so rdata stays stable between beats.
        rdata_d = {slot_q[0], slot_q[1], slot_q[2], mem_rdata};
        state_d = S_SEND;
      end
      S_SEND: begin
        if (out_ready) begin
          read_en = 1'b1;
          if (final_beat) begin
            out_last = 1'b1;
            state_d  = S_DONE;
          end else begin
            state_d = S_FETCH;
            k_d     = 2'd0;
            if (r_q == CW'(MATRIX_WIDTH - 2)) begin
              r_d = '0;
              c_d = c_q + CW'(1);
            end else begin
              r_d = r_q + CW'(2);
            end
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      r_q     <= '0;
      c_q     <= '0;
      slot_q  <= '{default: '0};
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      r_q     <= r_d;
      c_q     <= c_d;
      slot_q  <= slot_d;
      rdata_q <= rdata_d;
    end
  end

endmodule

// File: tb/tb_matrix_operand_streamer.sv
// Directed bench: expected beat table plus stall, restart, and mid-transfer reset sequences.
module tb_matrix_operand_streamer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        busy;
  logic        done;
  logic        mem_rd;
  logic [7:0]  mem_addr;
  logic [7:0]  mem_rdata = 8'h00;
  logic        out_ready;
  logic [31:0] rdata;
  logic        read_en;
  logic        out_last;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        last;
  } beat_t;

  beat_t      vecs [8];
  logic [7:0] addr_exp [4];
  logic [7:0] mem [256];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_rd) mem_rdata <= mem[mem_addr];
  end

  matrix_operand_streamer dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .mem_rd    (mem_rd),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .out_ready (out_ready),
    .rdata     (rdata),
    .read_en   (read_en),
    .out_last  (out_last)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_busy"},     32'(busy),     32'd0);
    chk({tag, "_done"},     32'(done),     32'd0);
    chk({tag, "_mem_rd"},   32'(mem_rd),   32'd0);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    chk({tag, "_read_en"},  32'(read_en),  32'd0);
    chk({tag, "_out_last"}, 32'(out_last), 32'd0);
    chk({tag, "_rdata"},    rdata,         32'd0);
  endtask

  // start asserted together with reset must not launch a transfer.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    check_idle("reset");
    reset = 1'b0;
    @(negedge clk);
    #1;
    chk("reset_wins_busy", 32'(busy), 32'd0);
  endtask

  task automatic run(input int stall_beat, input int start_beat, input int reset_beat);
    int         beats = 0;
    int         since = 0;
    int         naddr = 0;
    int         gap;
    bit         fin = 0;
    bit         rst_pend = 0;
    logic [7:0] addrs [4];

    @(negedge clk);
    start     = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("pre_start_busy", 32'(busy), 32'd0);

    for (int cyc = 1; cyc < 400 && !fin; cyc++) begin
      @(negedge clk);
      since++;
      start     = (beats == start_beat && since == 1);
      out_ready = !(beats == stall_beat && since >= 6 && since <= 10);
      if (rst_pend) begin
        reset = 1'b0;
        #1;
        check_idle("mid_reset");
        fin = 1;
      end else begin
        reset = (beats == reset_beat && since == 2);
        rst_pend = reset;
        #1;
        if (since == 1 && beats < 8)
          chk("busy_in_transfer", 32'(busy), 32'd1);
        if (beats == 0 && mem_rd && naddr < 4) begin
          addrs[naddr] = mem_addr;
          naddr++;
        end
        if (beats == stall_beat && since >= 6 && since <= 10) begin
          chk("stall_read_en", 32'(read_en), 32'd0);
          chk("stall_mem_rd",  32'(mem_rd),  32'd0);
          chk("stall_rdata",   rdata,        vecs[beats].rdata);
        end
        if (read_en) begin
          if (beats < 8) begin
            gap = (beats == stall_beat) ? 11 : 6;
            chk($sformatf("beat%0d_rdata", beats), rdata, vecs[beats].rdata);
            chk($sformatf("beat%0d_last", beats), 32'(out_last), 32'(vecs[beats].last));
            chk($sformatf("beat%0d_gap", beats), 32'(since), 32'(gap));
          end else begin
            chk("extra_beat", 32'(beats), 32'd7);
          end
          if (beats == 0) begin
            chk("beat0_addr_count", 32'(naddr), 32'd4);
            for (int i = 0; i < 4; i++)
              chk($sformatf("beat0_addr%0d", i), 32'(addrs[i]), 32'(addr_exp[i]));
          end
          beats++;
          since = 0;
        end else if (out_last) begin
          chk("stray_out_last", 32'(out_last), 32'd0);
        end
        if (done) begin
          chk("done_beat_count", 32'(beats), 32'd8);
          chk("done_one_after_last", 32'(since), 32'd1);
          for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            #1;
            chk("post_done_done", 32'(done),    32'd0);
            chk("post_done_busy", 32'(busy),    32'd0);
            chk("post_done_rd_en", 32'(read_en), 32'd0);
          end
          fin = 1;
        end
      end
    end
    if (!fin) begin
      checks++;
      errors++;
      $display("FAIL timeout: got beats=%0d required done within 400 cycles", beats);
    end
  endtask

  initial begin
    vecs[0] = '{32'h00041014, 1'b0};
    vecs[1] = '{32'h080C181C, 1'b0};
    vecs[2] = '{32'h01051115, 1'b0};
    vecs[3] = '{32'h090D191D, 1'b0};
    vecs[4] = '{32'h02061216, 1'b0};
    vecs[5] = '{32'h0A0E1A1E, 1'b0};
    vecs[6] = '{32'h03071317, 1'b0};
    vecs[7] = '{32'h0B0F1B1F, 1'b1};
    addr_exp[0] = 8'd0;
    addr_exp[1] = 8'd4;
    addr_exp[2] = 8'd16;
    addr_exp[3] = 8'd20;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);

    reset     = 1'b0;
    start     = 1'b0;
    out_ready = 1'b1;

    do_reset();
    run(-1, -1, -1);
    run(2, -1, -1);
    run(-1, 3, -1);
    run(-1, -1, 4);
    run(-1, -1, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
